// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle PC sequencer: opcodes, FSM states and PC-select codes.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [1:0] PC_INC    = 2'b00;
    localparam logic [1:0] PC_JUMP   = 2'b01;
    localparam logic [1:0] PC_BRANCH = 2'b10;
    localparam logic [1:0] PC_HOLD   = 2'b11;

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb,
        StHalt
    } state_e;

    function automatic logic is_legal(input logic [5:0] op);
        return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_HALT};
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle control FSM: steps each instruction through FETCH/DECODE/EXEC/MEM/WB and
// drives PC selection, datapath enables and a saturating retired-instruction count.
module pc_sequencer
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic [1:0]  pc_sig,
    output logic        ir_we,
    output logic        reg_we,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        mem_to_reg,
    output logic        halted,
    output logic        illegal,
    output logic [15:0] retired
);

    state_e     state_q, state_d;
    logic [5:0] opcode_q;
    logic       illegal_q;
    logic       retire;

    // DECODE acts on the live opcode; later states use the copy latched at the end of DECODE.
    always_comb begin
        state_d    = state_q;
        pc_sig     = PC_HOLD;
        ir_we      = 1'b0;
        reg_we     = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        mem_to_reg = 1'b0;
        halted     = 1'b0;

        case (state_q)
            StFetch: begin
                ir_we   = 1'b1;
                state_d = StDecode;
            end
            StDecode: begin
                case (opcode)
                    OP_RTYPE, OP_LW, OP_SW, OP_BEQ: state_d = StExec;
                    OP_J: begin
                        pc_sig  = PC_JUMP;
                        state_d = StFetch;
                    end
                    OP_HALT: state_d = StHalt;
                    default: begin
                        pc_sig  = PC_INC;
                        state_d = StFetch;
                    end
                endcase
            end
            StExec: begin
                case (opcode_q)
                    OP_BEQ: begin
                        pc_sig  = zero ? PC_BRANCH : PC_INC;
                        state_d = StFetch;
                    end
                    OP_LW, OP_SW: state_d = StMem;
                    default:      state_d = StWb;
                endcase
            end
            StMem: begin
                mem_rd = (opcode_q == OP_LW);
                mem_wr = (opcode_q == OP_SW);
                if (mem_ready) begin
                    if (opcode_q == OP_SW) begin
                        pc_sig  = PC_INC;
                        state_d = StFetch;
                    end else begin
                        state_d = StWb;
                    end
                end
            end
            StWb: begin
                reg_we     = 1'b1;
                mem_to_reg = (opcode_q == OP_LW);
                pc_sig     = PC_INC;
                state_d    = StFetch;
            end
            StHalt: halted = 1'b1;
            default: state_d = StFetch;
        endcase

        if (rst) begin
            pc_sig     = PC_HOLD;
            ir_we      = 1'b0;
            reg_we     = 1'b0;
            mem_rd     = 1'b0;
            mem_wr     = 1'b0;
            mem_to_reg = 1'b0;
            halted     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StFetch;
            opcode_q  <= OP_RTYPE;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == StDecode) begin
                opcode_q <= opcode;
                if (!is_legal(opcode)) begin
                    illegal_q <= 1'b1;
                end
            end
        end
    end

    // Every non-hold PC update marks the retire cycle of one instruction.
    assign retire  = (pc_sig != PC_HOLD);
    assign illegal = illegal_q;

    sat_counter #(
        .WIDTH(16)
    ) u_retired (
        .clk  (clk),
        .rst  (rst),
        .inc  (retire),
        .count(retired)
    );

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench: each instruction is expanded into its expected per-cycle outputs from the
// opcode sequence rules, with randomized don't-care inputs, wait states and resets.
module tb_pc_sequencer;

    localparam logic [5:0] RTYPE = 6'b000000;
    localparam logic [5:0] LW    = 6'b100011;
    localparam logic [5:0] SW    = 6'b101011;
    localparam logic [5:0] BEQ   = 6'b000100;
    localparam logic [5:0] JMP   = 6'b000010;
    localparam logic [5:0] HLT   = 6'b111111;

    localparam logic [1:0] INC = 2'b00, JUMP = 2'b01, BRANCH = 2'b10, HOLD = 2'b11;

    // Expected enable vector: {ir_we, reg_we, mem_rd, mem_wr, mem_to_reg, halted}
    localparam logic [5:0] EN_NONE = 6'b000000;
    localparam logic [5:0] EN_IR   = 6'b100000;
    localparam logic [5:0] EN_REG  = 6'b010000;
    localparam logic [5:0] EN_RD   = 6'b001000;
    localparam logic [5:0] EN_WR   = 6'b000100;
    localparam logic [5:0] EN_M2R  = 6'b000010;
    localparam logic [5:0] EN_HALT = 6'b000001;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic [1:0]  pc_sig;
    logic        ir_we, reg_we, mem_rd, mem_wr, mem_to_reg, halted, illegal;
    logic [15:0] retired;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] m_retired;
    logic        m_illegal;

    pc_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .opcode    (opcode),
        .zero      (zero),
        .mem_ready (mem_ready),
        .pc_sig    (pc_sig),
        .ir_we     (ir_we),
        .reg_we    (reg_we),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_to_reg(mem_to_reg),
        .halted    (halted),
        .illegal   (illegal),
        .retired   (retired)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] rop();
        return 6'($urandom);
    endfunction

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic legal(input logic [5:0] op);
        return (op == RTYPE) || (op == LW) || (op == SW) || (op == BEQ) || (op == JMP) ||
               (op == HLT);
    endfunction

    // Called at posedge+1: drive inputs, check mid-cycle, advance one clock, update model.
    task automatic cyc(input string tag, input logic [5:0] op, input logic z, input logic mr,
                       input logic [1:0] e_pc, input logic [5:0] e_en);
        opcode    = op;
        zero      = z;
        mem_ready = mr;
        #2;
        check_eq({tag, ".pc"}, 32'(pc_sig), 32'(e_pc));
        check_eq({tag, ".en"}, 32'({ir_we, reg_we, mem_rd, mem_wr, mem_to_reg, halted}),
                 32'(e_en));
        check_eq({tag, ".ill"}, 32'(illegal), 32'(m_illegal));
        check_eq({tag, ".ret"}, 32'(retired), 32'(m_retired));
        @(posedge clk);
        #1;
        if (e_pc != HOLD && m_retired != 16'hFFFF) m_retired++;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        m_retired = '0;
        m_illegal = 1'b0;
        #1;
        check_eq("rst.pc", 32'(pc_sig), 32'(HOLD));
        check_eq("rst.en", 32'({ir_we, reg_we, mem_rd, mem_wr, mem_to_reg, halted}),
                 32'(EN_NONE));
        check_eq("rst.ill", 32'(illegal), 32'(1'b0));
        check_eq("rst.ret", 32'(retired), 32'(16'h0));
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic run_instr(input logic [5:0] op, input logic z, input int nwait,
                             input int nhalt, input bit abort);
        logic [1:0] pc_e;
        logic [5:0] men;
        cyc("F", rop(), rb(), rb(), HOLD, EN_IR);
        pc_e = (op == JMP) ? JUMP : (!legal(op) ? INC : HOLD);
        cyc("D", op, rb(), rb(), pc_e, EN_NONE);
        if (!legal(op)) m_illegal = 1'b1;
        if (op == JMP || !legal(op)) return;
        if (op == HLT) begin
            repeat (nhalt) cyc("H", rop(), rb(), rb(), HOLD, EN_HALT);
            return;
        end
        pc_e = (op == BEQ) ? (z ? BRANCH : INC) : HOLD;
        cyc("E", rop(), z, rb(), pc_e, EN_NONE);
        if (op == BEQ) return;
        if (op == LW || op == SW) begin
            men = (op == LW) ? EN_RD : EN_WR;
            for (int i = 0; i < nwait; i++) cyc("M", rop(), rb(), 1'b0, HOLD, men);
            if (abort) begin
                mem_ready = 1'b0;
                #1;
                check_eq("abort.pre", 32'({mem_rd, mem_wr}), 32'(men[3:2]));
                do_reset();
                return;
            end
            cyc("M", rop(), rb(), 1'b1, (op == SW) ? INC : HOLD, men);
            if (op == SW) return;
        end
        cyc("W", rop(), rb(), rb(), INC, EN_REG | ((op == LW) ? EN_M2R : EN_NONE));
    endtask

    initial begin
        logic [5:0] op;
        int         sel;
        rst       = 1'b1;
        opcode    = '0;
        zero      = 1'b0;
        mem_ready = 1'b0;
        m_retired = '0;
        m_illegal = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Basic sequences
        run_instr(RTYPE, 1'b0, 0, 0, 1'b0);
        check_eq("rtype.ret", 32'(retired), 32'(16'd1));
        run_instr(LW, 1'b0, 3, 0, 1'b0);
        do_reset();
        run_instr(BEQ, 1'b1, 0, 0, 1'b0);
        run_instr(BEQ, 1'b0, 0, 0, 1'b0);
        check_eq("beq.ret", 32'(retired), 32'(16'd2));
        do_reset();
        run_instr(JMP, 1'b0, 0, 0, 1'b0);
        run_instr(6'b111110, 1'b0, 0, 0, 1'b0);
        check_eq("j_ill.ret", 32'(retired), 32'(16'd2));
        run_instr(RTYPE, 1'b0, 0, 0, 1'b0);
        check_eq("ill.sticky", 32'(illegal), 32'(1'b1));

        // HALT holds until reset; SW aborted by reset mid-MEM
        run_instr(HLT, 1'b0, 0, 20, 1'b0);
        do_reset();
        run_instr(SW, 1'b0, 2, 0, 1'b1);
        run_instr(SW, 1'b0, 1, 0, 1'b0);

        // Saturation from a preloaded count
        do_reset();
        force dut.u_retired.count_q = 16'hFFFE;
        m_retired = 16'hFFFE;
        #1;
        release dut.u_retired.count_q;
        repeat (3) run_instr(RTYPE, 1'b0, 0, 0, 1'b0);
        check_eq("sat.ret", 32'(retired), 32'(16'hFFFF));

        // Randomized instruction stream
        do_reset();
        for (int n = 0; n < 150; n++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0, 7: op = RTYPE;
                1, 8: op = LW;
                2:    op = SW;
                3, 9: op = BEQ;
                4:    op = JMP;
                5: begin
                    op = rop();
                    while (legal(op)) op = rop();
                end
                default: op = HLT;
            endcase
            run_instr(op, rb(), $urandom_range(0, 4), $urandom_range(1, 5),
                      (op == LW || op == SW) && ($urandom_range(0, 9) == 0));
            if (op == HLT) do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 clk  input  1  single system clock; all state SHALL update on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 opcode  input  6  instruction opcode from instruction register; valid from DECODE onward.
REQ-004 zero  input  1  ALU zero flag; sampled combinationally in EXEC.
REQ-005 mem_ready  input  1  data-memory completion handshake.
REQ-006 pc_sig  output  2  PC control: 00 increment, 01 jump target, 10 branch target, 11 hold.
REQ-007 ir_we  output  1  instruction-register write enable.
REQ-008 reg_we  output  1  register-file write enable.
REQ-009 mem_rd  output  1  data-memory read request.
REQ-010 mem_wr  output  1  data-memory write request.
REQ-011 mem_to_reg  output  1  writeback source select: 1 memory, 0 ALU.
REQ-012 halted  output  1  high while in HALT.
REQ-013 illegal  output  1  sticky flag: unknown opcode decoded.
REQ-014 retired  output  16  saturating count of retired instructions.

Function
REQ-015 FSM states SHALL be FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-016 Opcodes SHALL be: RTYPE 000000, LW 100011, SW 101011, BEQ 000100, J 000010, HALT 111111; anything else illegal.
REQ-017 Sequences: RTYPE F-D-E-WB-F; LW F-D-E-MEM-WB-F; SW F-D-E-MEM-F; BEQ F-D-E-F; J F-D-F; HALT F-D-HALT; illegal F-D-F.
REQ-018 FETCH SHALL last exactly one cycle with ir_we=1; ir_we SHALL be 0 in every other state.
REQ-019 MEM SHALL hold while mem_ready=0; mem_rd (LW) or mem_wr (SW) SHALL stay high every MEM cycle, low elsewhere.
REQ-020 MEM SHALL exit on the first cycle mem_ready=1; mem_ready outside MEM SHALL be ignored.
REQ-021 WB SHALL assert reg_we=1 for one cycle; mem_to_reg=1 for LW, 0 for RTYPE.
REQ-022 pc_sig SHALL be 11 in every cycle except the retire cycle of an instruction.
REQ-023 Retire cycles and pc_sig: RTYPE/LW in WB 00; SW in MEM with mem_ready=1 00; BEQ in EXEC 10 if zero=1 else 00; J in DECODE 01; illegal in DECODE 00.
REQ-024 HALT SHALL drive pc_sig=11 and all enables 0, and SHALL leave only via rst.
REQ-025 All outputs except retired/illegal SHALL be combinational decode of registered state, latched opcode and zero/mem_ready; no additional latency.
REQ-026 Opcode SHALL be latched in DECODE and held until next FETCH; opcode changes after DECODE SHALL be ignored.
REQ-027 retired SHALL increment by 1 on each retire cycle (pc_sig != 11), including illegal; saturate at 16'hFFFF.
REQ-028 illegal SHALL set in the DECODE cycle of an unknown opcode and remain set until rst.

Reset
REQ-029 rst=1 SHALL immediately force state=FETCH, retired=0, illegal=0, halted=0, latched opcode=RTYPE.
REQ-030 During rst=1 combinational outputs SHALL be forced: pc_sig=11, ir_we, reg_we, mem_rd, mem_wr, mem_to_reg=0.
REQ-031 rst mid-instruction (incl. mid-MEM wait or HALT) SHALL abandon it without retiring; first cycle after release SHALL be FETCH.

Structure
REQ-032 Shared package mips_pkg SHALL hold opcode constants, state enum, and pc_sig encodings PC_INC/PC_JUMP/PC_BRANCH/PC_HOLD.
REQ-033 Retire counter SHALL be sub-module sat_counter (parameter WIDTH=16, inputs clk, rst, inc).

Verification
REQ-034 RTYPE, mem_ready don't-care -> ir_we cycle1, reg_we cycle4, pc_sig=00 only cycle4, retired 0->1.
REQ-035 LW, mem_ready low 3 cycles -> mem_rd high 4 MEM cycles, then WB mem_to_reg=1, pc_sig=00, total 8 cycles.
REQ-036 BEQ zero=1 then BEQ zero=0 -> EXEC pc_sig=10, then 00; no reg_we; retired=2.
REQ-037 J, then opcode 111110 -> DECODE pc_sig=01; next DECODE pc_sig=00, illegal=1 sticky; retired=2.
REQ-038 HALT -> halted=1, pc_sig=11 for 20 cycles; rst pulse mid-MEM of SW -> mem_wr drops at once, retired=0, FETCH after release.
REQ-039 Preload retired=16'hFFFE, retire 3 RTYPE -> retired ends 16'hFFFF.
